// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_dispense_ctrl : queues vend/change events and sequences the product   |
// |   motor and coin hopper, with timeout-to-FAULT. Optional VEND_STATS_EN     |
// |   adds saturating vend/coin handshake counters.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vend_dispense_ctrl #(
  parameter int QDEPTH = 4,
  parameter int TMO    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vend_in,
  input  logic [1:0]  change_in,
  output logic        q_full,
  output logic        overflow,
  output logic        motor_on,
  input  logic        motor_done,
  output logic        coin_req,
  input  logic        coin_ack,
  output logic        busy,
  output logic        fault,
  input  logic        fault_clr
`ifdef VEND_STATS_EN
  ,
  output logic [15:0] vend_cnt,
  output logic [15:0] coin_cnt
`endif
);

  localparam int         AW       = $clog2(QDEPTH);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_MOTOR    = 3'd2,
    S_COIN     = 3'd3,
    S_COIN_GAP = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  tmo_cnt, tmo_nx;
  logic [1:0]  coins, coins_nx;
  logic        vend_lat, vend_nx;

  logic [2:0]  q_mem [QDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        q_empty, enq_req, deq, enq_ok, drop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign enq_req = vend_in | (|change_in);
  assign deq     = (state == S_IDLE) && !q_empty;
  assign enq_ok  = enq_req && (!q_full || deq);
  assign drop    = enq_req && q_full && !deq;

  assign busy  = (state != S_IDLE) || !q_empty;
  assign fault = (state == S_FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
      if (deq)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) q_mem[wr_ptr[AW-1:0]] <= {vend_in, change_in};
  end

  // A fresh drop outranks a simultaneous clear so the loss is never hidden.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (fault_clr) overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tmo_cnt  <= '0;
      coins    <= '0;
      vend_lat <= 1'b0;
    end else begin
      state    <= state_nx;
      tmo_cnt  <= tmo_nx;
      coins    <= coins_nx;
      vend_lat <= vend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmo_nx   = tmo_cnt;
    coins_nx = coins;
    vend_nx  = vend_lat;
    motor_on = 1'b0;
    coin_req = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          state_nx = S_LOAD;
          vend_nx  = q_mem[rd_ptr[AW-1:0]][2];
          coins_nx = q_mem[rd_ptr[AW-1:0]][1:0];
        end
      end
      S_LOAD: begin
        tmo_nx = '0;
        if (vend_lat)          state_nx = S_MOTOR;
        else if (coins != 2'd0) state_nx = S_COIN;
        else                   state_nx = S_IDLE;
      end
      S_MOTOR: begin
        motor_on = 1'b1;
        // Handshake is tested first so an ack on the expiry cycle still wins.
        if (motor_done) begin
          tmo_nx   = '0;
          vend_nx  = 1'b0;
          state_nx = (coins != 2'd0) ? S_COIN : S_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = S_FAULT;
          vend_nx  = 1'b0;
          coins_nx = '0;
        end else begin
          tmo_nx = tmo_cnt + 8'd1;
        end
      end
      S_COIN: begin
        coin_req = 1'b1;
        if (coin_ack) begin
          coins_nx = coins - 2'd1;
          state_nx = S_COIN_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = S_FAULT;
          coins_nx = '0;
        end else begin
          tmo_nx = tmo_cnt + 8'd1;
        end
      end
      S_COIN_GAP: begin
        tmo_nx   = '0;
        state_nx = (coins != 2'd0) ? S_COIN : S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef VEND_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vend_cnt <= '0;
      coin_cnt <= '0;
    end else if (fault_clr) begin
      vend_cnt <= '0;
      coin_cnt <= '0;
    end else begin
      if ((state == S_MOTOR) && motor_done && (vend_cnt != 16'hFFFF))
        vend_cnt <= vend_cnt + 16'd1;
      if ((state == S_COIN) && coin_ack && (coin_cnt != 16'hFFFF))
        coin_cnt <= coin_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
